dll_phase_ctrl: RTL and testbench
=================================

Name: dll_phase_ctrl

Overview:
- Digital loop controller directly downstream of the divide-by-N stage in the frequency-multiplying DLL.
- Consumes the divided feedback (DIV_N) and a reference-edge strobe, both in the clk_out domain.
- Measures which edge arrives first and by how many clk_out cycles.
- Steps the delay-line control code and asserts lock once the two edges stay aligned.

Parameters:
- CODE_W, 6, width of the delay-line control code.
- CODE_INIT, 32, ctrl_code value after reset.
- TIMEOUT, 31, max clk_out cycles to wait for the second edge of a pair.
- LOCK_TOL, 1, max gap in cycles that counts as aligned.
- LOCK_CNT, 8, consecutive aligned comparisons required to assert lock.
- COARSE_TH, 4, gap above which the coarse step is used.
- COARSE_STEP, 4, code step size for large gaps; the fine step is 1.

Ports:
- clk_out, input, 1, DLL output clock; sole clock of the block.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, loop enable.
- DIV_N, input, 1, divider output. It is high except for one cycle per divided period.
- ref_pulse, input, 1, one-cycle strobe at each reference rising edge, already synchronised to clk_out.
- ctrl_code, output, CODE_W, delay-line control code.
- up, output, 1, one-cycle pulse when the code is incremented.
- dn, output, 1, one-cycle pulse when the code is decremented.
- lock, output, 1, loop locked.
- timeout_err, output, 1, one-cycle pulse when a comparison is abandoned.

Behaviour:
- Reset values: ctrl_code=CODE_INIT, up=0, dn=0, lock=0, timeout_err=0, FSM=IDLE, gap counter=0, lock counter=0, DIV_N edge register=1.
- div_ev: registered DIV_N is 1 and current DIV_N is 0, i.e. the falling edge that marks the divided-period boundary. div_ev is valid in the same cycle DIV_N goes low.
- FSM states and transitions:
  - IDLE:
    - div_ev and ref_pulse in the same cycle: aligned compare with gap=0, stay in IDLE.
    - div_ev only: go to WAIT_REF, gap=1.
    - ref_pulse only: go to WAIT_DIV, gap=1.
  - WAIT_REF / WAIT_DIV:
    - gap increments each cycle without the awaited event.
    - Awaited event arrives: compare with the current gap, return to IDLE.
    - A repeat of the first event restarts the gap at 1 and stays in the state.
    - gap reaching TIMEOUT without the event: pulse timeout_err, clear the lock counter, drop lock, go to IDLE, code unchanged.
- Compare action, one cycle after the closing event (registered):
  - gap<=LOCK_TOL: no code change. Lock counter increments, saturating at LOCK_CNT. lock=1 when the counter reaches LOCK_CNT.
  - gap>LOCK_TOL: lock counter=0 and lock=0. Step = COARSE_STEP if gap>COARSE_TH, else 1.
    - Divided edge came first (closed from WAIT_REF): output is early, so ctrl_code += step and pulse up.
    - Reference came first (closed from WAIT_DIV): ctrl_code -= step and pulse dn.
- Saturation:
  - ctrl_code clamps at 0 and at 2^CODE_W-1.
  - up/dn still pulse only if the code actually changed.
  - No wrap-around ever.
- up and dn are never high together. At most one compare fires per cycle.
- en=0:
  - FSM forced to IDLE, gap and lock counter cleared, lock=0.
  - ctrl_code held; no up/dn/timeout_err pulses.
  - Events in the cycle en returns to 1 are processed normally.
- N changes are invisible to this block; it reacts only to DIV_N edges.
- Asynchronous reset mid-comparison returns every register to its reset value immediately.

Test Plan:
- Reset with CODE_INIT=32; ref_pulse and div_ev coincident for 8 periods -> ctrl_code stays 32; lock rises 1 cycle after the 8th compare.
- div_ev 2 cycles before ref_pulse -> single up pulse, ctrl_code 32->33. At 6 cycles ahead -> ctrl_code +4 (coarse).
- ref_pulse 3 cycles before div_ev while locked -> lock drops, dn pulse, ctrl_code -1, lock counter restarts.
- ctrl_code=0 and reference repeatedly early by 6 -> code stays 0, no dn pulses; mirror case at 63 -> no up pulses.
- div_ev with no ref_pulse for 31 cycles -> timeout_err single pulse, FSM back to IDLE, code unchanged, lock=0.
- en deasserted in WAIT_DIV, then reasserted -> no compare fires for the abandoned pair, lock=0, ctrl_code unchanged. rst_n pulsed mid-WAIT_REF -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/dll_phase_ctrl.sv
// dll_phase_ctrl: phase detector and code stepper for the frequency-multiplying DLL.
// Measures the cycle gap between the divided-feedback boundary (DIV_N falling)
// and the reference strobe, nudges the delay-line code toward alignment and
// raises lock after LOCK_CNT consecutive aligned comparisons.
module dll_phase_ctrl #(
  parameter int CODE_W      = 6,
  parameter int CODE_INIT   = 32,
  parameter int TIMEOUT     = 31,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 8,
  parameter int COARSE_TH   = 4,
  parameter int COARSE_STEP = 4
) (
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              en,
  input  logic              DIV_N,
  input  logic              ref_pulse,
  output logic [CODE_W-1:0] ctrl_code,
  output logic              up,
  output logic              dn,
  output logic              lock,
  output logic              timeout_err
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam int LC_W  = $clog2(LOCK_CNT + 1);
  localparam logic [GAP_W-1:0]  GAP_TOL  = GAP_W'(LOCK_TOL);
  localparam logic [GAP_W-1:0]  GAP_CTH  = GAP_W'(COARSE_TH);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);
  localparam logic [LC_W-1:0]   LC_MAX   = LC_W'(LOCK_CNT);
  localparam logic [CODE_W:0]   CODE_MAX = {1'b0, {CODE_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, WAIT_REF, WAIT_DIV} state_e;

  state_e            state_q, state_d;
  logic              div_q;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              up_q, up_d, dn_q, dn_d, lock_q, lock_d, tmo_q, tmo_d;

  logic              div_ev;
  logic              cmp, cmp_up;
  logic [GAP_W-1:0]  cmp_gap;
  logic [CODE_W:0]   step, sum;

  assign div_ev = div_q & ~DIV_N;

  // Pair tracking FSM plus the compare action applied at the closing edge.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    lcnt_d  = lcnt_q;
    code_d  = code_q;
    lock_d  = lock_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    tmo_d   = 1'b0;
    cmp     = 1'b0;
    cmp_up  = 1'b0;
    cmp_gap = '0;
    step    = '0;
    sum     = '0;

    if (!en) begin
      state_d = IDLE;
      gap_d   = '0;
      lcnt_d  = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_ev && ref_pulse) begin
            cmp = 1'b1;
          end else if (div_ev) begin
            state_d = WAIT_REF;
            gap_d   = GAP_W'(1);
          end else if (ref_pulse) begin
            state_d = WAIT_DIV;
            gap_d   = GAP_W'(1);
          end
        end
        WAIT_REF, WAIT_DIV: begin
          // Awaited event wins over a repeat of the opening event.
          if ((state_q == WAIT_REF) ? ref_pulse : div_ev) begin
            cmp     = 1'b1;
            cmp_up  = (state_q == WAIT_REF);
            cmp_gap = gap_q;
            state_d = IDLE;
            gap_d   = '0;
          end else if ((state_q == WAIT_REF) ? div_ev : ref_pulse) begin
            gap_d = GAP_W'(1);
          end else if (gap_q >= GAP_LAST) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
            gap_d   = '0;
            lcnt_d  = '0;
            lock_d  = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
        end
      endcase

      if (cmp) begin
        if (cmp_gap <= GAP_TOL) begin
          if (lcnt_q != LC_MAX) lcnt_d = lcnt_q + 1'b1;
          if (lcnt_d == LC_MAX) lock_d = 1'b1;
        end else begin
          lcnt_d = '0;
          lock_d = 1'b0;
          step   = (cmp_gap > GAP_CTH) ? (CODE_W+1)'(COARSE_STEP) : (CODE_W+1)'(1);
          if (cmp_up) begin
            sum    = {1'b0, code_q} + step;
            code_d = (sum > CODE_MAX) ? CODE_MAX[CODE_W-1:0] : sum[CODE_W-1:0];
            up_d   = (code_d != code_q);
          end else begin
            code_d = ({1'b0, code_q} < step) ? '0 : code_q - step[CODE_W-1:0];
            dn_d   = (code_d != code_q);
          end
        end
      end
    end
  end

  // State and output registers; DIV_N history keeps tracking while disabled so
  // an edge in the re-enable cycle is seen correctly.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 1'b1;
      gap_q   <= '0;
      lcnt_q  <= '0;
      code_q  <= CODE_W'(CODE_INIT);
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      lock_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= DIV_N;
      gap_q   <= gap_d;
      lcnt_q  <= lcnt_d;
      code_q  <= code_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ctrl_code   = code_q;
  assign up          = up_q;
  assign dn          = dn_q;
  assign lock        = lock_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_dll_phase_ctrl.sv
// Scoreboard bench for dll_phase_ctrl: stimulus pushes the expected output
// event {up,dn,timeout_err,lock,ctrl_code}; a monitor pops and compares each
// time the DUT pulses up/dn/timeout_err or changes lock.
module tb_dll_phase_ctrl;
  logic       clk_out = 1'b0;
  logic       rst_n, en, DIV_N, ref_pulse;
  logic [5:0] ctrl_code;
  logic       up, dn, lock, timeout_err;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  dll_phase_ctrl dut (
    .clk_out(clk_out), .rst_n(rst_n), .en(en), .DIV_N(DIV_N), .ref_pulse(ref_pulse),
    .ctrl_code(ctrl_code), .up(up), .dn(dn), .lock(lock), .timeout_err(timeout_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [9:0] ev(input bit u, input bit d, input bit t, input bit l, input int code);
    logic [5:0] c;
    c = code[5:0];
    return {u, d, t, l, c};
  endfunction

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit d, input bit r);
    DIV_N = ~d;
    ref_pulse = r;
    tick();
    DIV_N = 1'b1;
    ref_pulse = 1'b0;
  endtask

  // lead > 0: divided edge first by lead cycles; lead < 0: reference first.
  task automatic pair(input int lead);
    if (lead == 0) drive(1'b1, 1'b1);
    else if (lead > 0) begin
      drive(1'b1, 1'b0); idle(lead - 1); drive(1'b0, 1'b1);
    end else begin
      drive(1'b0, 1'b1); idle(-lead - 1); drive(1'b1, 1'b0);
    end
    idle(4);
  endtask

  // n aligned pairs (gap 0 or 1); optionally expect lock to rise on the last.
  task automatic aligned(input int n, input bit lock_at_end, input int code);
    int pat[4];
    pat = '{0, 1, -1, 0};
    for (int i = 0; i < n; i++) begin
      if (lock_at_end && i == n - 1) begin
        exp_q.push_back(ev(0, 0, 0, 1, code));
        drive(1'b1, 1'b1);
        chk("lock_rise_next_cycle", lock, 1);
        idle(4);
      end else pair(pat[i % 4]);
    end
  endtask

  // Monitor: compare every visible output event against the scoreboard.
  initial begin
    logic lock_prev;
    logic [9:0] act;
    lock_prev = 1'b0;
    forever begin
      @(negedge clk_out);
      if (rst_n && (up || dn || timeout_err || lock != lock_prev)) begin
        act = {up, dn, timeout_err, lock, ctrl_code};
        if (exp_q.size() == 0) chk("unexpected_event", int'(act), 0);
        else chk("event", int'(act), int'(exp_q.pop_front()));
      end
      lock_prev = lock;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; DIV_N = 1'b1; ref_pulse = 1'b0;
    #12;
    chk("reset_code", ctrl_code, 32);
    chk("reset_outs", {up, dn, lock, timeout_err}, 0);
    rst_n = 1'b1; en = 1'b1;
    idle(3);

    // Aligned for 8 periods: code stays, lock on 8th.
    aligned(8, 1'b1, 32);
    chk("aligned_code", ctrl_code, 32);

    // Divided edge early by 2 (fine), then by 6 (coarse).
    exp_q.push_back(ev(1, 0, 0, 0, 33)); pair(2);
    exp_q.push_back(ev(1, 0, 0, 0, 37)); pair(6);

    // Relock, then reference early by 3: lock drops, dn, counter restarts.
    aligned(8, 1'b1, 37);
    exp_q.push_back(ev(0, 1, 0, 0, 36)); pair(-3);
    aligned(7, 1'b0, 36);
    chk("lock_restart_7", lock, 0);
    aligned(1, 1'b1, 36);

    // Drive down to 0: fine step, coarse steps, last one clamps 3->0.
    exp_q.push_back(ev(0, 1, 0, 0, 35)); pair(-2);
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(ev(0, 1, 0, 0, 35 - 4 * k)); pair(-6);
    end
    exp_q.push_back(ev(0, 1, 0, 0, 0)); pair(-6);
    pair(-6); pair(-6); pair(-2);
    chk("floor_code", ctrl_code, 0);

    // Mirror: up to 63 with clamp 60->63, then no further up pulses.
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(ev(1, 0, 0, 0, 4 * k)); pair(6);
    end
    exp_q.push_back(ev(1, 0, 0, 0, 63)); pair(6);
    pair(6); pair(2);
    chk("ceil_code", ctrl_code, 63);

    // Timeout while locked: single pulse, lock drops, code unchanged.
    aligned(8, 1'b1, 63);
    exp_q.push_back(ev(0, 0, 1, 0, 63));
    drive(1'b1, 1'b0);
    idle(40);
    chk("timeout_code", ctrl_code, 63);
    chk("timeout_queue_drained", exp_q.size(), 0);

    // Disable while waiting on DIV: pair abandoned, lock drops, code held.
    aligned(8, 1'b1, 63);
    drive(1'b0, 1'b1);
    idle(3);
    exp_q.push_back(ev(0, 0, 0, 0, 63));
    en = 1'b0;
    idle(2);
    drive(1'b1, 1'b0);
    idle(4);
    chk("disabled_lock", lock, 0);
    chk("disabled_code", ctrl_code, 63);
    // Reference in the re-enable cycle opens a new pair normally.
    en = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 62));
    pair(-3);

    // Async reset mid-WAIT_REF: outputs return before any clock edge.
    exp_q.push_back(ev(1, 0, 0, 0, 63)); pair(6);
    drive(1'b1, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_code", ctrl_code, 32);
    chk("async_reset_outs", {up, dn, lock, timeout_err}, 0);
    #3 rst_n = 1'b1;
    tick();
    // FSM restarted in IDLE: a lone reference opens a pair that times out.
    exp_q.push_back(ev(0, 0, 1, 0, 32));
    drive(1'b0, 1'b1);
    idle(40);
    chk("post_reset_code", ctrl_code, 32);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
